// File: rtl/slot_pkg.sv
// Shared definitions for the slot machine SPI command path.
// Contents: opcode constants, frame length, reel/credit types, receiver FSM states.
package slot_pkg;

  localparam logic [7:0] OP_SPIN  = 8'h01;
  localparam logic [7:0] OP_WIN   = 8'h02;
  localparam logic [7:0] OP_TOTAL = 8'h03;

  localparam int FRAME_BITS = 24;

  typedef logic [2:0]  sprite_idx_t;
  typedef logic [11:0] credits_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } spi_state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// N-flop synchronizer for one asynchronous pin, with a registered edge detector.
// Ports:
//   clk, reset_n  system clock, async active-low reset
//   pin           asynchronous input
//   level         synchronized level
//   rise, fall    one-clk pulses on synchronized transitions
module spi_pin_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = sync_q[STAGES-1] & ~prev_q;
  assign fall  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_command_receiver.sv
// SPI mode-0 target receiving fixed 24-bit command frames (spin result, win
// credits, total credits) and returning a status byte on sdo.
// Ports:
//   clk, reset_n            pixel clock (>= 8x sclk), async active-low reset
//   sclk, copi, cs          SPI pins from the MCU (cs active-low)
//   sdo                     status byte, MSB first, during the first 8 bits
//   done                    spin-finished level from the memory controller
//   reel1/2/3_idx           reel sprite indices, start_spin pulse
//   win_credits, is_win     last win amount and its update pulse
//   total_credits, is_total last credit total and its update pulse
//
// state  | meaning
// IDLE   | waiting for cs to fall
// SHIFT  | frame in progress, shifting copi in and status out
// COMMIT | one cycle: decode a complete frame and update outputs
module spi_command_receiver
  import slot_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [3:0] STATUS_ID   = 4'hA
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sclk,
  input  logic        copi,
  input  logic        cs,
  output logic        sdo,
  input  logic        done,
  output sprite_idx_t reel1_idx,
  output sprite_idx_t reel2_idx,
  output sprite_idx_t reel3_idx,
  output logic        start_spin,
  output credits_t    win_credits,
  output logic        is_win,
  output credits_t    total_credits,
  output logic        is_total
);

  localparam logic [4:0] FRAME_CNT = 5'(FRAME_BITS);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic copi_lvl, copi_rise, copi_fall;

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset_n(reset_n), .pin(sclk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .reset_n(reset_n), .pin(cs),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
    .clk(clk), .reset_n(reset_n), .pin(copi),
    .level(copi_lvl), .rise(copi_rise), .fall(copi_fall)
  );

  // Only edges of sclk/cs and the level of copi drive the logic.
  logic unused_sync;
  assign unused_sync = ^{sclk_lvl, cs_lvl, copi_rise, copi_fall};

  spi_state_t  state;
  logic [4:0]  bit_cnt;
  logic [23:0] rx_reg;
  logic [7:0]  tx_reg;
  logic        cs_fall_pend;
  logic        done_d;
  logic        done_sticky;
  logic        is_win_seen;
  logic        spin_busy;

  logic       done_rise;
  logic [7:0] status;

  assign done_rise = done & ~done_d;
  assign status    = {STATUS_ID, 1'b0, is_win_seen, spin_busy, done_sticky};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      bit_cnt       <= '0;
      rx_reg        <= '0;
      tx_reg        <= '0;
      cs_fall_pend  <= 1'b0;
      done_d        <= 1'b0;
      done_sticky   <= 1'b0;
      is_win_seen   <= 1'b0;
      spin_busy     <= 1'b0;
      sdo           <= 1'b0;
      reel1_idx     <= '0;
      reel2_idx     <= '0;
      reel3_idx     <= '0;
      start_spin    <= 1'b0;
      win_credits   <= '0;
      is_win        <= 1'b0;
      total_credits <= '0;
      is_total      <= 1'b0;
    end else begin
      start_spin <= 1'b0;
      is_win     <= 1'b0;
      is_total   <= 1'b0;
      done_d     <= done;

      if (is_win)     is_win_seen <= 1'b1;
      if (start_spin) spin_busy   <= 1'b1;
      if (done_rise)  spin_busy   <= 1'b0;

      case (state)
        ST_IDLE: begin
          sdo <= 1'b0;
          if (cs_fall || cs_fall_pend) begin
            state        <= ST_SHIFT;
            cs_fall_pend <= 1'b0;
            tx_reg       <= status;
            sdo          <= status[7];
            bit_cnt      <= '0;
            done_sticky  <= 1'b0;
          end
        end

        ST_SHIFT: begin
          if (cs_rise) begin
            state <= (bit_cnt == FRAME_CNT) ? ST_COMMIT : ST_IDLE;
            sdo   <= 1'b0;
          end else begin
            if (sclk_rise && bit_cnt != FRAME_CNT) begin
              rx_reg  <= {rx_reg[22:0], copi_lvl};
              bit_cnt <= bit_cnt + 5'd1;
            end
            if (sclk_fall) begin
              tx_reg <= {tx_reg[6:0], 1'b0};
              // tx_reg[6] is the bit that becomes tx_reg[7] after this shift.
              sdo    <= (bit_cnt < 5'd8) ? tx_reg[6] : 1'b0;
            end
          end
        end

        ST_COMMIT: begin
          state <= ST_IDLE;
          // The edge detector only pulses once; remember a fall seen here.
          if (cs_fall) cs_fall_pend <= 1'b1;
          case (rx_reg[23:16])
            OP_SPIN: begin
              reel1_idx   <= rx_reg[15:13];
              reel2_idx   <= rx_reg[12:10];
              reel3_idx   <= rx_reg[9:7];
              start_spin  <= 1'b1;
              is_win_seen <= 1'b0;
            end
            OP_WIN: begin
              win_credits <= rx_reg[11:0];
              is_win      <= 1'b1;
            end
            OP_TOTAL: begin
              total_credits <= rx_reg[11:0];
              is_total      <= 1'b1;
            end
            default: ;
          endcase
        end

        default: state <= ST_IDLE;
      endcase

      // A done edge in the same cycle as the frame-start clear must survive.
      if (done_rise) done_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_command_receiver.sv
module tb_spi_command_receiver;
  import slot_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sclk = 1'b0;
  logic        copi = 1'b0;
  logic        cs = 1'b1;
  logic        done = 1'b0;
  logic        sdo;
  sprite_idx_t reel1_idx, reel2_idx, reel3_idx;
  logic        start_spin, is_win, is_total;
  credits_t    win_credits, total_credits;

  spi_command_receiver #(.SYNC_STAGES(2), .STATUS_ID(4'hA)) dut (
    .clk(clk), .reset_n(reset_n), .sclk(sclk), .copi(copi), .cs(cs),
    .sdo(sdo), .done(done),
    .reel1_idx(reel1_idx), .reel2_idx(reel2_idx), .reel3_idx(reel3_idx),
    .start_spin(start_spin), .win_credits(win_credits), .is_win(is_win),
    .total_credits(total_credits), .is_total(is_total)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Pulse monitors: cycles each strobe was high, and back-to-back highs.
  int spin_cycles = 0, win_cycles = 0, total_cycles = 0, width_err = 0;
  logic spin_p = 0, win_p = 0, total_p = 0;
  always @(negedge clk) begin
    if (start_spin) spin_cycles++;
    if (is_win)     win_cycles++;
    if (is_total)   total_cycles++;
    if ((start_spin && spin_p) || (is_win && win_p) || (is_total && total_p)) width_err++;
    spin_p  = start_spin;
    win_p   = is_win;
    total_p = is_total;
  end

  // Reference model: architectural state computed from the frame rules.
  int   m_r1, m_r2, m_r3, m_win, m_total;
  int   m_spins = 0, m_wins = 0, m_totals = 0;
  bit   m_win_seen, m_busy, m_sticky;

  task automatic model_reset();
    m_r1 = 0; m_r2 = 0; m_r3 = 0; m_win = 0; m_total = 0;
    m_win_seen = 0; m_busy = 0; m_sticky = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".reel1"}, 32'(reel1_idx), 32'(m_r1));
    chk({tag, ".reel2"}, 32'(reel2_idx), 32'(m_r2));
    chk({tag, ".reel3"}, 32'(reel3_idx), 32'(m_r3));
    chk({tag, ".win"}, 32'(win_credits), 32'(m_win));
    chk({tag, ".total"}, 32'(total_credits), 32'(m_total));
    chk({tag, ".spin_pulses"}, 32'(spin_cycles), 32'(m_spins));
    chk({tag, ".win_pulses"}, 32'(win_cycles), 32'(m_wins));
    chk({tag, ".total_pulses"}, 32'(total_cycles), 32'(m_totals));
    chk({tag, ".sdo_idle"}, 32'(sdo), 32'd0);
  endtask

  task automatic pulse_done();
    done = 1'b1;
    repeat (3) @(negedge clk);
    done = 1'b0;
    repeat (3) @(negedge clk);
    m_sticky = 1; m_busy = 0;
  endtask

  // One SPI frame of n bits (first bit = bits[n-1]); 8 clk per sclk period.
  task automatic xfer(input string tag, input logic [31:0] bits, input int n);
    logic [7:0]  st;
    logic [7:0]  exp_st;
    logic [23:0] f;
    int          op;
    st = '0;
    exp_st = {4'hA, 1'b0, m_win_seen, m_busy, m_sticky};
    m_sticky = 0;
    cs = 1'b0;
    copi = bits[n-1];
    #40;
    for (int i = 0; i < n; i++) begin
      if (i < 8) st[7-i] = sdo;
      sclk = 1'b1;
      #40;
      sclk = 1'b0;
      if (i + 1 < n) copi = bits[n-2-i];
      #40;
    end
    cs = 1'b1;
    copi = 1'b0;
    if (n >= FRAME_BITS) begin
      f  = 24'(bits >> (n - FRAME_BITS));
      op = int'(f[23:16]);
      if (op == 1) begin
        m_r1 = int'(f[15:13]); m_r2 = int'(f[12:10]); m_r3 = int'(f[9:7]);
        m_spins++; m_win_seen = 0; m_busy = 1;
      end else if (op == 2) begin
        m_win = int'(f[11:0]); m_wins++; m_win_seen = 1;
      end else if (op == 3) begin
        m_total = int'(f[11:0]); m_totals++;
      end
    end
    repeat (40) @(negedge clk);
    if (n >= 8) chk({tag, ".status"}, 32'(st), 32'(exp_st));
    check_outputs(tag);
  endtask

  initial begin
    logic [31:0] d;
    int          n, ex, sel;
    logic [7:0]  op8;

    model_reset();
    repeat (3) @(negedge clk);
    chk("reset.all_zero",
        32'({reel1_idx, reel2_idx, reel3_idx, start_spin, is_win, is_total, sdo}), 32'd0);
    chk("reset.credits", 32'({win_credits, total_credits}), 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // Status after done, then immediately again, then after a spin.
    pulse_done();
    xfer("status_done", 32'h000000, 24);
    xfer("status_clear", 32'h000000, 24);
    xfer("spin_721", 32'h01E880, 24);
    chk("spin_721.reel_lit", 32'({reel1_idx, reel2_idx, reel3_idx}), 32'({3'd7, 3'd2, 3'd1}));
    xfer("status_busy", 32'h000000, 24);

    xfer("win_1000", 32'h0203E8, 24);
    chk("win_1000.lit", 32'(win_credits), 32'd1000);
    xfer("total_4095", 32'h030FFF, 24);
    chk("total_4095.lit", 32'(total_credits), 32'd4095);

    xfer("abort_13", 32'h01E880 >> 11, 13);
    xfer("spin_100", 32'h012000, 24);
    xfer("unknown_7f", 32'h7FFFFF, 24);
    xfer("overlen_30", {8'h0, 24'h01A500} << 6 | 32'h2B, 30);

    // Reset mid-frame.
    cs = 1'b0;
    #40;
    for (int i = 0; i < 5; i++) begin
      copi = i[0]; sclk = 1'b1; #40; sclk = 1'b0; #40;
    end
    reset_n = 1'b0;
    #20;
    model_reset();
    check_outputs("midreset");
    cs = 1'b1; copi = 1'b0; sclk = 1'b0;
    #20;
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    check_outputs("after_reset");
    xfer("win_5", 32'h020005, 24);

    // Randomized frames against the model.
    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 2) == 0) pulse_done();
      sel = int'($urandom_range(0, 3));
      op8 = (sel == 0) ? 8'($urandom) : 8'(sel);
      d   = {8'h0, op8, 16'($urandom)};
      n   = 24;
      sel = int'($urandom_range(0, 9));
      if (sel == 7 || sel == 8) begin
        ex = int'($urandom_range(1, 8));
        d  = (d << ex) | ($urandom & ((32'd1 << ex) - 32'd1));
        n  = 24 + ex;
      end else if (sel == 9) begin
        n = int'($urandom_range(1, 23));
        d = d >> (24 - n);
      end
      xfer($sformatf("rand%0d", k), d, n);
    end

    chk("pulse_width", 32'(width_err), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
